// File: rtl/pkd_array_rx.sv
// rtl/pkd_array_rx.sv - serial-to-packed-array receiver, MSB first, valid/ready word output.
// Optional even-parity trailer bit enabled by defining PKD_RX_PARITY_EN.
module pkd_array_rx #(
  parameter  int D0   = 5,
  parameter  int D1   = 4,
  parameter  int D2   = 3,
  localparam int WORD = D0 * D1 * D2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sin_valid,
  input  logic            sin_data,
  input  logic            sin_last,
  output logic            sin_ready,
  output logic [WORD-1:0] arr_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frame_err,
  output logic            par_err,
  output logic [7:0]      frm_cnt
);

  localparam int CW = $clog2(WORD + 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DRAIN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, shift_en, fe_n, pe_n, deliver;

  assign sin_ready = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = sin_valid && sin_ready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_en = 1'b0;
    fe_n     = 1'b0;
    pe_n     = 1'b0;
    deliver  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_en = 1'b1;
          if (sin_last) begin
            fe_n = 1'b1;
          end else begin
            state_n = SHIFT;
            cnt_n   = CW'(1);
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (cnt < LAST_IDX) begin
            shift_en = 1'b1;
            if (sin_last) begin
              fe_n    = 1'b1;
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
`ifdef PKD_RX_PARITY_EN
          end else if (cnt == LAST_IDX) begin
            if (sin_last) begin
              fe_n    = 1'b1;
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              shift_en = 1'b1;
              cnt_n    = cnt + 1'b1;
            end
          end else begin
            // Parity bit: checked against the completed payload, never shifted in.
            cnt_n = '0;
            if (sin_last) begin
              if ((^arr_out) ^ sin_data) begin
                pe_n    = 1'b1;
                state_n = IDLE;
              end else begin
                state_n = HOLD;
              end
            end else begin
              fe_n    = 1'b1;
              state_n = DRAIN;
            end
          end
`else
          end else begin
            shift_en = 1'b1;
            cnt_n    = '0;
            if (sin_last) begin
              state_n = HOLD;
            end else begin
              fe_n    = 1'b1;
              state_n = DRAIN;
            end
          end
`endif
        end
      end
      DRAIN: begin
        if (accept && sin_last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          deliver = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      arr_out   <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      frm_cnt   <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_err <= fe_n;
      par_err   <= pe_n;
      if (shift_en) arr_out <= {arr_out[WORD-2:0], sin_data};
      if (deliver)  frm_cnt <= frm_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pkd_array_rx.sv
// tb/tb_pkd_array_rx.sv - scoreboard bench for pkd_array_rx; build with PKD_RX_PARITY_EN for parity cases.
module tb_pkd_array_rx;
  localparam int WORD = 60;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sin_valid = 1'b0, sin_data = 1'b0, sin_last = 1'b0;
  logic            sin_ready;
  logic [WORD-1:0] arr_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            frame_err, par_err;
  logic [7:0]      frm_cnt;

  pkd_array_rx dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_last(sin_last), .sin_ready(sin_ready), .arr_out(arr_out),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .par_err(par_err), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int fe_cnt = 0, pe_cnt = 0, vcnt = 0;
  logic fe_prev = 1'b0;
  logic [WORD-1:0] exp_q[$];
  logic [7:0]      expc_q[$];
  logic [7:0]      exp_cnt = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) begin
        fe_cnt++;
        chk("frame_err_pulse_width", {63'd0, fe_prev}, 64'd0);
      end
      if (par_err) pe_cnt++;
      if (out_valid) vcnt++;
      if ((frame_err || par_err) && out_valid)
        chk("err_with_valid", 64'd1, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'd1, 64'd0);
        end else begin
          chk("word_data", {4'd0, arr_out}, {4'd0, exp_q.pop_front()});
          chk("word_frm_cnt", {56'd0, frm_cnt}, {56'd0, expc_q.pop_front()});
        end
      end
    end
    fe_prev = frame_err;
  end

  task automatic expect_word(input logic [WORD-1:0] w);
    exp_q.push_back(w);
    expc_q.push_back(exp_cnt);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic send_bit(input logic d, input logic l);
    int t = 0;
    sin_valid = 1'b1; sin_data = d; sin_last = l;
    while (!sin_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) chk("sin_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    sin_valid = 1'b0; sin_last = 1'b0;
  endtask

  task automatic send_frame(input logic [WORD-1:0] w);
`ifdef PKD_RX_PARITY_EN
    for (int i = WORD - 1; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit(^w, 1'b1);
`else
    for (int i = WORD - 1; i >= 0; i--) send_bit(w[i], i == 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [WORD-1:0] w;
    idle(2);
    chk("rst_arr_out", {4'd0, arr_out}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
    chk("rst_par_err", {63'd0, par_err}, 64'd0);
    chk("rst_frm_cnt", {56'd0, frm_cnt}, 64'd0);
    rst_n = 1'b1;
    idle(1);
    chk("idle_sin_ready", {63'd0, sin_ready}, 64'd1);

    // all ones, consumer ready
    out_ready = 1'b1; vcnt = 0;
    w = {WORD{1'b1}};
    expect_word(w);
    send_frame(w);
    idle(3);
    chk("ones_valid_cycles", vcnt, 1);
    chk("ones_frm_cnt", {56'd0, frm_cnt}, 64'd1);

    // backpressure for 5 cycles
    out_ready = 1'b0;
    w = 60'h123_4567_89AB_CDEF;
    expect_word(w);
    send_frame(w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_arr_out", {4'd0, arr_out}, {4'd0, w});
      chk("hold_sin_ready", {63'd0, sin_ready}, 64'd0);
    end
    out_ready = 1'b1;
    idle(4);
    chk("hold_frm_cnt", {56'd0, frm_cnt}, 64'd2);
    chk("hold_released", {63'd0, out_valid}, 64'd0);

    // early last on bit 10, gaps inside the frame
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(i[0], i == 9);
      if (i == 4) idle(3);
    end
    idle(3);
    chk("early_frame_err", fe_cnt, 1);
    chk("early_no_valid", vcnt, 0);
    w = '0;
    expect_word(w);
    send_frame(w);
    idle(3);
    chk("zeros_frm_cnt", {56'd0, frm_cnt}, 64'd3);

    // 64-bit overlong frame, drained with one error
    vcnt = 0;
    for (int i = 0; i < 64; i++) send_bit(1'b1, i == 63);
    idle(3);
    chk("long_frame_err", fe_cnt, 2);
    chk("long_no_valid", vcnt, 0);
    w = 60'hA5A_5C3C_0FF0_1234;
    expect_word(w);
    send_frame(w);
    idle(3);
    chk("after_long_frm_cnt", {56'd0, frm_cnt}, 64'd4);

    // reset mid-frame
    for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_arr_out", {4'd0, arr_out}, 64'd0);
    chk("midrst_frm_cnt", {56'd0, frm_cnt}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    w = 60'hFED_CBA9_8765_4321;
    expect_word(w);
    send_frame(w);
    idle(3);
    chk("midrst_new_frm_cnt", {56'd0, frm_cnt}, 64'd1);

`ifdef PKD_RX_PARITY_EN
    w = 60'h1;
    expect_word(w);
    for (int i = WORD - 1; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit(1'b1, 1'b1);
    idle(3);
    chk("par_good_frm_cnt", {56'd0, frm_cnt}, 64'd2);
    vcnt = 0;
    for (int i = WORD - 1; i >= 0; i--) send_bit(w[i], 1'b0);
    send_bit(1'b0, 1'b1);
    idle(3);
    chk("par_bad_par_err", pe_cnt, 1);
    chk("par_bad_no_valid", vcnt, 0);
    chk("par_bad_frm_cnt", {56'd0, frm_cnt}, 64'd2);
`else
    chk("nopar_par_err", pe_cnt, 0);
`endif

    // 256 frames from reset wrap the counter to 0
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      w = {4'(n), 56'h0F0_F0F0_F0F0_F0F} ^ {52'd0, 8'(n)};
      expect_word(w);
      send_frame(w);
    end
    idle(3);
    chk("wrap_frm_cnt", {56'd0, frm_cnt}, 64'd0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
